// File: rtl/mousetrap_pkg.sv
// Shared types and defaults for the mousetrap pipeline front-end arbiter.
package mousetrap_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StErr
  } mt_state_e;

  localparam int unsigned DefNreq       = 4;
  localparam int unsigned DefDw         = 8;
  localparam int unsigned DefTimeoutCyc = 255;

  // Index width, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mousetrap_rr_pick.sv
// Combinational round-robin pick: first set request at or above the pointer, with wrap.
module mousetrap_rr_pick
  import mousetrap_pkg::*;
#(
  parameter int unsigned NREQ = DefNreq,
  parameter int unsigned IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_rr_ptr,
  output logic            o_valid,
  output logic [IW-1:0]   o_idx
);

  logic [NREQ-1:0] w_rot;
  logic [IW-1:0]   w_off;
  logic [IW:0]     w_sum;

  // Rotate so the pointer lands on bit 0; the lowest set bit is then the offset.
  assign w_rot   = NREQ'({i_req, i_req} >> i_rr_ptr);
  assign o_valid = |i_req;

  always_comb begin
    w_off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IW'(k);
    end
  end

  assign w_sum = {1'b0, w_off} + {1'b0, i_rr_ptr};
  assign o_idx = (w_sum >= (IW + 1)'(NREQ)) ? IW'(w_sum - (IW + 1)'(NREQ)) : w_sum[IW-1:0];

endmodule

// File: rtl/mousetrap_arbiter.sv
// Round-robin clocked front-end driving bundled data and a two-phase ri into a
// mousetrap stage; the returning ai is synchronised and turned into a one-hot ack.
module mousetrap_arbiter
  import mousetrap_pkg::*;
#(
  parameter int unsigned NREQ        = DefNreq,
  parameter int unsigned DW          = DefDw,
  parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
  input  logic                     phi1,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DW-1:0]       data_in,
  output logic [NREQ-1:0]          ack,
  output logic                     ri,
  output logic [DW-1:0]            data_out,
  input  logic                     ai,
  output logic                     busy,
  output logic [idx_w(NREQ)-1:0]   gnt_idx,
  output logic                     err
);

  localparam int unsigned IW = idx_w(NREQ);
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  mt_state_e       r_state, w_state_d;
  logic            r_ai_meta, r_ai_s;
  logic            r_ri, w_ri_d;
  logic [DW-1:0]   r_data, w_data_d;
  logic [IW-1:0]   r_gnt, w_gnt_d;
  logic [NREQ-1:0] r_ack, w_ack_d;
  logic [IW-1:0]   r_ptr, w_ptr_d;
  logic [CW-1:0]   r_cnt, w_cnt_d;
  logic            r_err, w_err_d;
  logic            w_pick_valid;
  logic [IW-1:0]   w_pick_idx;

  mousetrap_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .i_req    (req),
    .i_rr_ptr (r_ptr),
    .o_valid  (w_pick_valid),
    .o_idx    (w_pick_idx)
  );

  always_comb begin
    w_state_d = r_state;
    w_ri_d    = r_ri;
    w_data_d  = r_data;
    w_gnt_d   = r_gnt;
    w_ack_d   = '0;
    w_ptr_d   = r_ptr;
    w_cnt_d   = r_cnt;
    w_err_d   = r_err;
    unique case (r_state)
      StIdle: begin
        if (r_ai_s != r_ri) begin
          w_err_d   = 1'b1;
          w_state_d = StErr;
        end else if (w_pick_valid && (r_ack == '0)) begin
          // No grant on the ack cycle: the acked requester gets a cycle to drop req.
          w_data_d  = data_in[w_pick_idx*DW +: DW];
          w_gnt_d   = w_pick_idx;
          w_ri_d    = ~r_ri;
          w_cnt_d   = '0;
          w_state_d = StWait;
        end
      end
      StWait: begin
        if (r_ai_s == r_ri) begin
          w_ack_d   = NREQ'(1) << r_gnt;
          w_ptr_d   = (r_gnt == IW'(NREQ - 1)) ? '0 : r_gnt + IW'(1);
          w_state_d = StIdle;
        end else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
          w_err_d   = 1'b1;
          w_state_d = StErr;
        end else begin
          w_cnt_d = r_cnt + CW'(1);
        end
      end
      StErr:   ;
      default: w_state_d = StErr;
    endcase
  end

  always_ff @(posedge phi1) begin
    if (reset) begin
      r_state   <= StIdle;
      r_ai_meta <= 1'b0;
      r_ai_s    <= 1'b0;
      r_ri      <= 1'b0;
      r_data    <= '0;
      r_gnt     <= '0;
      r_ack     <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_ai_meta <= ai;
      r_ai_s    <= r_ai_meta;
      r_ri      <= w_ri_d;
      r_data    <= w_data_d;
      r_gnt     <= w_gnt_d;
      r_ack     <= w_ack_d;
      r_ptr     <= w_ptr_d;
      r_cnt     <= w_cnt_d;
      r_err     <= w_err_d;
    end
  end

  assign ack      = r_ack;
  assign ri       = r_ri;
  assign data_out = r_data;
  assign busy     = (r_state == StWait);
  assign gnt_idx  = r_gnt;
  assign err      = r_err;

endmodule

// File: tb/tb_mousetrap_arbiter.sv
// Randomised bench for mousetrap_arbiter; the bench plays the mousetrap stage and
// predicts grants, data and ack timing from a transaction-level round-robin model.
module tb_mousetrap_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned TMO  = 16;

  logic                phi1 = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [NREQ*DW-1:0]  data_in;
  logic [NREQ-1:0]     ack;
  logic                ri;
  logic [DW-1:0]       data_out;
  logic                ai;
  logic                busy;
  logic [1:0]          gnt_idx;
  logic                err;

  int   n_pass   = 0;
  int   n_checks = 0;
  logic m_ri;
  int   m_ptr;
  bit   m_ack_cycle;

  mousetrap_arbiter #(
    .NREQ        (NREQ),
    .DW          (DW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .phi1     (phi1),
    .reset    (reset),
    .req      (req),
    .data_in  (data_in),
    .ack      (ack),
    .ri       (ri),
    .data_out (data_out),
    .ai       (ai),
    .busy     (busy),
    .gnt_idx  (gnt_idx),
    .err      (err)
  );

  always #5 phi1 = ~phi1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // First requester at or above the pointer, wrapping.
  function automatic int pick(input logic [NREQ-1:0] m, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge phi1);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ai    = 1'b0;
    req   = '0;
    tick();
    chk("rst_edge_ri", ri, 0);
    chk("rst_edge_busy", busy, 0);
    chk("rst_edge_ack", ack, 0);
    tick();
    reset       = 1'b0;
    m_ri        = 1'b0;
    m_ptr       = 0;
    m_ack_cycle = 1'b0;
    chk("rst_ri", ri, 0);
    chk("rst_data", data_out, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt_idx, 0);
    chk("rst_err", err, 0);
  endtask

  task automatic grant(input logic [NREQ-1:0] mask, input bit rnd, output int g,
                       output logic [DW-1:0] exp_d);
    req = mask;
    if (rnd) data_in = $urandom;
    g     = pick(mask, m_ptr);
    exp_d = data_in[g*DW +: DW];
    if (m_ack_cycle) begin
      tick();
      chk("no_grant_on_ack_ri", ri, m_ri);
      chk("ack_one_cycle", ack, 0);
      chk("ack_cycle_busy", busy, 0);
      m_ack_cycle = 1'b0;
    end
    tick();
    m_ri = ~m_ri;
    chk("grant_ri", ri, m_ri);
    chk("grant_idx", gnt_idx, g);
    chk("grant_data", data_out, exp_d);
    chk("grant_busy", busy, 1);
    chk("grant_ack", ack, 0);
  endtask

  task automatic run_token(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] wmask,
                           input bit rnd, input int d);
    int          g;
    logic [DW-1:0] exp_d;
    grant(mask, rnd, g, exp_d);
    req     = wmask;
    data_in = $urandom;
    repeat (d) tick();
    chk("wait_busy", busy, 1);
    chk("wait_data_hold", data_out, exp_d);
    ai = m_ri;
    tick();
    tick();
    chk("ack_early", ack, 0);
    chk("busy_before_ack", busy, 1);
    tick();
    chk("ack_onehot", ack, 32'(1) << g);
    chk("ack_busy", busy, 0);
    chk("ack_err", err, 0);
    m_ptr       = (g + 1) % NREQ;
    m_ack_cycle = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          g;
    logic [DW-1:0] ed;
    reset   = 1'b1;
    ai      = 1'b0;
    req     = '0;
    data_in = '0;
    do_reset();

    // Single requester, ai returned 5 cycles after ri.
    data_in = '0;
    data_in[DW-1:0] = 8'hA5;
    run_token(4'b0001, 4'b0001, 1'b0, 5);

    // All requesting: rotation 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < 5; i++) run_token(4'b1111, 4'b1111, 1'b1, $urandom_range(0, 4));

    // req[1] dropped mid-WAIT, next grant goes above 1.
    do_reset();
    run_token(4'b0110, 4'b1100, 1'b1, 2);
    run_token(4'b1100, 4'b1100, 1'b1, 1);

    // Randomised traffic.
    for (int i = 0; i < 40; i++) begin
      run_token(NREQ'($urandom_range(1, 15)), NREQ'($urandom_range(0, 15)), 1'b1,
                $urandom_range(0, 8));
    end

    // Reset in WAIT abandons the token; req[2] is then served normally.
    do_reset();
    grant(4'b0100, 1'b1, g, ed);
    tick();
    tick();
    do_reset();
    run_token(4'b0100, 4'b0100, 1'b1, 3);

    // Spurious ai transition in IDLE.
    req = '0;
    tick();
    tick();
    m_ack_cycle = 1'b0;
    ai = ~m_ri;
    tick();
    tick();
    chk("spur_err_early", err, 0);
    tick();
    chk("spur_err", err, 1);
    chk("spur_ri", ri, m_ri);
    chk("spur_busy", busy, 0);
    req = 4'b1111;
    repeat (3) tick();
    chk("spur_frozen_ri", ri, m_ri);
    chk("spur_sticky", err, 1);
    do_reset();

    // Timeout with no ai return.
    grant(4'b1000, 1'b1, g, ed);
    for (int i = 0; i < int'(TMO) - 1; i++) begin
      tick();
      chk("tmo_no_ack", ack, 0);
    end
    chk("tmo_err_early", err, 0);
    chk("tmo_busy_early", busy, 1);
    tick();
    chk("tmo_err", err, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_ack", ack, 0);
    req     = NREQ'($urandom_range(1, 15));
    data_in = $urandom;
    repeat (4) tick();
    chk("tmo_frozen_ri", ri, m_ri);
    chk("tmo_frozen_gnt", gnt_idx, g);
    chk("tmo_frozen_data", data_out, ed);
    chk("tmo_frozen_ack", ack, 0);
    chk("tmo_sticky", err, 1);
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
